// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - Elastic ID/EX pipeline register with two-entry skid buffer and stall counter
module id_ex_stage #(
    parameter int CTRL_W = 12
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [31:0]       InPCPlus4,
    input  logic [31:0]       InRsData,
    input  logic [31:0]       InRtData,
    input  logic [31:0]       InImmExt,
    input  logic [4:0]        InRt,
    input  logic [4:0]        InRd,
    input  logic [4:0]        InShamt,
    input  logic [CTRL_W-1:0] InCtrl,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [31:0]       OutPCPlus4,
    output logic [31:0]       OutRsData,
    output logic [31:0]       OutRtData,
    output logic [31:0]       OutImmExt,
    output logic [4:0]        OutRt,
    output logic [4:0]        OutRd,
    output logic [4:0]        OutShamt,
    output logic [CTRL_W-1:0] OutCtrl,
    output logic [31:0]       StallCount
);

    localparam int PW = 4 * 32 + 3 * 5 + CTRL_W;

    logic [PW-1:0] in_bundle;
    logic [PW-1:0] m_data;
    logic [PW-1:0] s_data;
    logic          m_valid;
    logic          s_valid;
    logic          in_ready_q;
    logic [31:0]   stall_cnt;

    logic accept;
    logic drain;
    logic m_load_s;
    logic m_load_in;
    logic s_load_in;
    logic m_valid_nxt;
    logic s_valid_nxt;

    assign in_bundle = {InPCPlus4, InRsData, InRtData, InImmExt, InRt, InRd, InShamt, InCtrl};
    assign {OutPCPlus4, OutRsData, OutRtData, OutImmExt, OutRt, OutRd, OutShamt, OutCtrl} = m_data;
    assign OutValid   = m_valid;
    assign InReady    = in_ready_q;
    assign StallCount = stall_cnt;

    assign accept = InValid & in_ready_q;
    assign drain  = m_valid & OutReady;

    always_comb begin
        m_load_s    = 1'b0;
        m_load_in   = 1'b0;
        s_load_in   = 1'b0;
        m_valid_nxt = m_valid;
        s_valid_nxt = s_valid;
        if (!m_valid || drain) begin
            if (s_valid) begin
                m_load_s    = 1'b1;
                m_valid_nxt = 1'b1;
                s_load_in   = accept;
                s_valid_nxt = accept;
            end else begin
                m_load_in   = accept;
                m_valid_nxt = accept;
            end
        end else if (accept) begin
            // M is stalled, so the new beat parks in the skid entry
            s_load_in   = 1'b1;
            s_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            m_data     <= '0;
            s_data     <= '0;
            m_valid    <= 1'b0;
            s_valid    <= 1'b0;
            in_ready_q <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            if (m_valid && !OutReady && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (m_load_s) begin
                m_data <= s_data;
            end else if (m_load_in) begin
                m_data <= in_bundle;
            end
            if (s_load_in) begin
                s_data <= in_bundle;
            end
            // Payload may go stale on a flush; only the valid bits are cleared
            if (Flush) begin
                m_valid    <= 1'b0;
                s_valid    <= 1'b0;
                in_ready_q <= 1'b1;
            end else begin
                m_valid    <= m_valid_nxt;
                s_valid    <= s_valid_nxt;
                in_ready_q <= ~s_valid_nxt;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - Scoreboard testbench for id_ex_stage
module tb_id_ex_stage;

    localparam int CTRL_W = 12;
    localparam int PW     = 4 * 32 + 3 * 5 + CTRL_W;

    logic              Clk = 1'b0;
    logic              Rst_n;
    logic              Flush;
    logic              InValid;
    logic              InReady;
    logic [31:0]       InPCPlus4, InRsData, InRtData, InImmExt;
    logic [4:0]        InRt, InRd, InShamt;
    logic [CTRL_W-1:0] InCtrl;
    logic              OutValid;
    logic              OutReady;
    logic [31:0]       OutPCPlus4, OutRsData, OutRtData, OutImmExt;
    logic [4:0]        OutRt, OutRd, OutShamt;
    logic [CTRL_W-1:0] OutCtrl;
    logic [31:0]       StallCount;

    logic [PW-1:0] tb_beat;
    logic [PW-1:0] out_vec;

    assign {InPCPlus4, InRsData, InRtData, InImmExt, InRt, InRd, InShamt, InCtrl} = tb_beat;
    assign out_vec = {OutPCPlus4, OutRsData, OutRtData, OutImmExt, OutRt, OutRd, OutShamt, OutCtrl};

    id_ex_stage #(.CTRL_W(CTRL_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush),
        .InValid(InValid), .InReady(InReady),
        .InPCPlus4(InPCPlus4), .InRsData(InRsData), .InRtData(InRtData), .InImmExt(InImmExt),
        .InRt(InRt), .InRd(InRd), .InShamt(InShamt), .InCtrl(InCtrl),
        .OutValid(OutValid), .OutReady(OutReady),
        .OutPCPlus4(OutPCPlus4), .OutRsData(OutRsData), .OutRtData(OutRtData), .OutImmExt(OutImmExt),
        .OutRt(OutRt), .OutRd(OutRd), .OutShamt(OutShamt), .OutCtrl(OutCtrl),
        .StallCount(StallCount)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the stage is a FIFO of capacity 2 whose head is the output
    logic [PW-1:0] sb_q[$];
    logic          mdl_ready = 1'b0;
    logic [31:0]   mdl_stall = '0;
    logic          last_acc  = 1'b0;
    logic          mon_en    = 1'b0;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge Clk) begin
        logic acc;
        logic drn;
        acc = InValid && mdl_ready;
        drn = (sb_q.size() > 0) && OutReady;
        if (!Rst_n) begin
            sb_q.delete();
            mdl_ready = 1'b0;
            mdl_stall = '0;
            acc       = 1'b0;
        end else begin
            if ((sb_q.size() > 0) && !OutReady && (mdl_stall != 32'hFFFF_FFFF))
                mdl_stall = mdl_stall + 1;
            if (Flush) begin
                sb_q.delete();
                mdl_ready = 1'b1;
            end else begin
                if (drn) void'(sb_q.pop_front());
                if (acc) sb_q.push_back(tb_beat);
                mdl_ready = (sb_q.size() < 2);
            end
        end
        last_acc = acc;
    end

    always @(negedge Clk) begin
        if (mon_en) begin
            check("in_ready", PW'(InReady), PW'(mdl_ready));
            check("out_valid", PW'(OutValid), PW'(sb_q.size() > 0));
            check("stall_count", PW'(StallCount), PW'(mdl_stall));
            if (OutValid && sb_q.size() > 0)
                check("payload", out_vec, sb_q[0]);
        end
    end

    function automatic logic [PW-1:0] rand_beat();
        logic [PW-1:0] b;
        for (int i = 0; i < PW; i++) b[i] = 1'($urandom_range(0, 1));
        return b;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #2;
        end
    endtask

    task automatic send(input logic [PW-1:0] b);
        int tries;
        tries   = 0;
        InValid = 1'b1;
        tb_beat = b;
        do begin
            step(1);
            tries++;
        end while (!last_acc && tries < 50);
        if (!last_acc) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: beat not accepted within %0d cycles", tries);
        end
        InValid = 1'b0;
    endtask

    logic [31:0] imm_tab[8];
    logic [PW-1:0] b;

    initial begin
        imm_tab = '{32'hFFFF_8000, 32'h0000_7FFF, 32'h0000_0000, 32'hFFFF_FFFF,
                    32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_0001};
        Rst_n    = 1'b0;
        Flush    = 1'b0;
        InValid  = 1'b0;
        OutReady = 1'b0;
        tb_beat  = '0;
        step(2);
        mon_en = 1'b1;
        check("reset_payload", out_vec, '0);
        Rst_n = 1'b1;
        step(2);

        // Streaming
        OutReady = 1'b1;
        foreach (imm_tab[i]) begin
            b = rand_beat();
            b[CTRL_W + 15 +: 32] = imm_tab[i];
            send(b);
        end
        step(3);

        // Backpressure fill: A, B absorbed, C waits
        OutReady = 1'b0;
        send(rand_beat());
        send(rand_beat());
        InValid = 1'b1;
        tb_beat = rand_beat();
        step(4);
        OutReady = 1'b1;
        while (!last_acc) step(1);
        InValid = 1'b0;
        step(4);

        // Flush while full with C offered
        OutReady = 1'b0;
        send(rand_beat());
        send(rand_beat());
        InValid = 1'b1;
        tb_beat = rand_beat();
        Flush   = 1'b1;
        step(1);
        Flush   = 1'b0;
        InValid = 1'b0;
        step(2);
        OutReady = 1'b1;
        step(2);

        // Reset mid-operation
        OutReady = 1'b0;
        send(rand_beat());
        send(rand_beat());
        InValid = 1'b1;
        tb_beat = rand_beat();
        Rst_n   = 1'b0;
        step(1);
        check("midreset_imm", PW'(OutImmExt), '0);
        check("midreset_payload", out_vec, '0);
        Rst_n   = 1'b1;
        InValid = 1'b0;
        step(3);

        // Saturation
        OutReady = 1'b0;
        send(rand_beat());
        step(1);
        force dut.stall_cnt = 32'hFFFF_FFFD;
        mdl_stall = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt;
        step(4);
        check("stall_saturated", PW'(StallCount), PW'(32'hFFFF_FFFF));
        OutReady = 1'b1;
        step(2);

        // Random traffic
        Rst_n = 1'b0;
        step(1);
        Rst_n = 1'b1;
        step(1);
        tb_beat = rand_beat();
        for (int c = 0; c < 3000; c++) begin
            if (last_acc || !InValid) tb_beat = rand_beat();
            InValid  = 1'($urandom_range(0, 99) < 70);
            OutReady = 1'($urandom_range(0, 99) < 65);
            Flush    = 1'($urandom_range(0, 99) < 10);
            step(1);
        end
        InValid  = 1'b0;
        Flush    = 1'b0;
        OutReady = 1'b1;
        step(4);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
